interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 134 +++++++++++++
 tb/tb_interrupt_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// ============================================================================
// Module      : interrupt_controller
// Description : Eight-level fixed-priority interrupt controller with
//               edge-latched requests, mask/in-service registers and an
//               INT/intack vector handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interrupt_controller #(
  parameter logic [15:0] VEC_BASE = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  irq,
  input  logic        intack,
  output logic        INT,
  output logic [15:0] vector,
  input  logic        sel,
  input  logic        a0,
  input  logic        memwt,
  input  logic [15:0] wdata,
  output logic [15:0] rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_irr;
  logic [7:0] r_imr;
  logic [7:0] r_isr;
  logic [7:0] r_irq_d;
  logic [2:0] r_lvl;
  logic       r_int;

  logic [7:0] w_isr_low;
  logic [7:0] w_allow;
  logic [7:0] w_cand;
  logic       w_found;
  logic [2:0] w_win;
  logic [7:0] w_rise;
  logic       w_ack;
  logic       w_eoi;
  logic       w_imr_wr;
  logic [7:0] w_ack_bits;
  logic [7:0] w_eoi_bits;
  logic [7:0] w_irr_next;
  logic [7:0] w_isr_next;
  logic       w_unused;

  // Only levels strictly above the highest-priority in-service level may
  // interrupt; with isr empty the subtraction wraps to all ones.
  assign w_isr_low = r_isr & (~r_isr + 8'd1);
  assign w_allow   = w_isr_low - 8'd1;
  assign w_cand    = r_irr & ~r_imr & w_allow;

  always_comb begin
    w_found = 1'b0;
    w_win   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_found = 1'b1;
        w_win   = 3'(i);
      end
    end
  end

  assign w_rise     = irq & ~r_irq_d;
  assign w_ack      = (r_state == REQ) && intack;
  assign w_eoi      = sel && memwt && a0;
  assign w_imr_wr   = sel && memwt && !a0;
  assign w_ack_bits = w_ack ? (8'b1 << r_lvl) : 8'h00;
  assign w_eoi_bits = w_eoi ? (8'b1 << wdata[2:0]) : 8'h00;

  // Sets are applied after clears so a coincident set always wins.
  assign w_irr_next = (r_irr & ~w_ack_bits) | w_rise;
  assign w_isr_next = (r_isr & ~w_eoi_bits) | w_ack_bits;

  assign w_unused = &{1'b0, wdata[15:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_irr   <= 8'h00;
      r_imr   <= 8'hFF;
      r_isr   <= 8'h00;
      r_irq_d <= 8'h00;
      r_lvl   <= 3'd0;
      r_int   <= 1'b0;
    end else begin
      r_irq_d <= irq;
      r_irr   <= w_irr_next;
      r_isr   <= w_isr_next;
      if (w_imr_wr) begin
        r_imr <= wdata[7:0];
      end
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_lvl   <= w_win;
            r_state <= REQ;
            r_int   <= 1'b1;
          end
        end
        REQ: begin
          if (intack) begin
            r_state <= ACK;
            r_int   <= 1'b0;
          end
        end
        ACK: begin
          if (!intack) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_int   <= 1'b0;
        end
      endcase
    end
  end

  assign INT    = r_int;
  assign vector = (r_state != IDLE) ? (VEC_BASE + {13'd0, r_lvl}) : 16'h0000;
  assign rdata  = !sel ? 16'h0000 : (a0 ? {8'h00, r_irr} : {r_isr, r_imr});

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// ============================================================================
// Module      : tb_interrupt_controller
// Description : Randomized self-checking bench for interrupt_controller
//               against a behavioural priority/handshake model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_interrupt_controller;

  localparam logic [15:0] C_VB = 16'h0100;
  localparam int C_IDLE = 0;
  localparam int C_REQ  = 1;
  localparam int C_ACK  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  irq;
  logic        intack;
  logic        sel;
  logic        a0;
  logic        memwt;
  logic [15:0] wdata;
  wire         INT;
  wire  [15:0] vector;
  wire  [15:0] rdata;

  interrupt_controller #(.VEC_BASE(C_VB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .irq    (irq),
    .intack (intack),
    .INT    (INT),
    .vector (vector),
    .sel    (sel),
    .a0     (a0),
    .memwt  (memwt),
    .wdata  (wdata),
    .rdata  (rdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending/mask/in-service sets plus handshake phase.
  bit [7:0] m_irr, m_imr, m_isr, m_irqd;
  int       m_phase;
  int       m_lvl;

  task automatic chk_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_irr = 8'h00; m_imr = 8'hFF; m_isr = 8'h00; m_irqd = 8'h00;
    m_phase = C_IDLE; m_lvl = 0;
  endtask

  // Applies the inputs present at the coming rising edge to the model.
  task automatic model_edge();
    int       low, best, n_phase, n_lvl;
    bit [7:0] n_irr, n_isr, n_imr;
    low = 8;
    for (int i = 7; i >= 0; i--) if (m_isr[i]) low = i;
    best = -1;
    for (int i = 0; i < 8; i++)
      if (best < 0 && m_irr[i] && !m_imr[i] && i < low) best = i;
    n_irr = m_irr; n_isr = m_isr; n_imr = m_imr;
    n_phase = m_phase; n_lvl = m_lvl;
    if (sel && memwt && !a0) n_imr = wdata[7:0];
    if (sel && memwt && a0) n_isr[wdata[2:0]] = 1'b0;
    if (m_phase == C_IDLE && best >= 0) begin
      n_phase = C_REQ; n_lvl = best;
    end else if (m_phase == C_REQ && intack) begin
      n_irr[m_lvl] = 1'b0; n_isr[m_lvl] = 1'b1; n_phase = C_ACK;
    end else if (m_phase == C_ACK && !intack) begin
      n_phase = C_IDLE;
    end
    for (int i = 0; i < 8; i++) if (irq[i] && !m_irqd[i]) n_irr[i] = 1'b1;
    m_irr = n_irr; m_isr = n_isr; m_imr = n_imr; m_irqd = irq;
    m_phase = n_phase; m_lvl = n_lvl;
  endtask

  task automatic check_outputs(input string tag);
    logic s_sel, s_a0;
    logic [15:0] exp_vec;
    exp_vec = (m_phase != C_IDLE) ? 16'(C_VB + m_lvl) : 16'h0000;
    chk_eq({tag, "_int"}, {15'd0, INT}, {15'd0, m_phase == C_REQ});
    chk_eq({tag, "_vec"}, vector, exp_vec);
    s_sel = sel; s_a0 = a0;
    sel = 1'b1; a0 = 1'b0; #1;
    chk_eq({tag, "_isr_imr"}, rdata, {m_isr, m_imr});
    a0 = 1'b1; #1;
    chk_eq({tag, "_irr"}, rdata, {8'h00, m_irr});
    sel = 1'b0; #1;
    chk_eq({tag, "_nosel"}, rdata, 16'h0000);
    sel = s_sel; a0 = s_a0;
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_bus();
    sel = 1'b0; a0 = 1'b0; memwt = 1'b0; wdata = 16'h0000;
  endtask

  task automatic cpu_write(input logic addr, input logic [15:0] d, input string tag);
    sel = 1'b1; a0 = addr; memwt = 1'b1; wdata = d;
    cycle(tag);
    idle_bus();
  endtask

  task automatic peek_irr(output logic [15:0] v);
    logic s_sel, s_a0;
    s_sel = sel; s_a0 = a0;
    sel = 1'b1; a0 = 1'b1; #1;
    v = rdata;
    sel = s_sel; a0 = s_a0;
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_eq({tag, "_int"}, {15'd0, INT}, 16'h0000);
    chk_eq({tag, "_vec"}, vector, 16'h0000);
    sel = 1'b1; a0 = 1'b0; #1;
    chk_eq({tag, "_regs"}, rdata, 16'h00FF);
    sel = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    intack = 1'b1;
    irq = 8'h00;
    idle_bus();
    cycle({tag, "_ackign"});
    intack = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    int resets;
    rst_n = 1'b0; irq = 8'h00; intack = 1'b0;
    idle_bus();
    model_reset();
    #12;
    chk_eq("rst_int", {15'd0, INT}, 16'h0000);
    chk_eq("rst_vec", vector, 16'h0000);
    sel = 1'b1; a0 = 1'b0; #1;
    chk_eq("rst_regs", rdata, 16'h00FF);
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst");

    // Masked pending request, then unmask.
    irq = 8'h10; cycle("m_rise");
    chk_eq("m_int0", {15'd0, INT}, 16'h0000);
    peek_irr(v);
    chk_eq("m_irr", v, 16'h0010);
    irq = 8'h00;
    cpu_write(1'b0, 16'h00EF, "m_wr");
    cycle("m_req");
    chk_eq("m_vec", vector, 16'(C_VB + 4));
    intack = 1'b1; cycle("m_ack");
    intack = 1'b0; cycle("m_rel");
    cpu_write(1'b1, 16'h0004, "m_eoi");

    // Single request round trip.
    cpu_write(1'b0, 16'h0000, "s_wr");
    irq = 8'h04; cycle("s_rise");
    irq = 8'h00; cycle("s_req");
    chk_eq("s_vec", vector, 16'(C_VB + 2));
    intack = 1'b1; cycle("s_ack");
    intack = 1'b0; cycle("s_rel");
    cpu_write(1'b1, 16'h0002, "s_eoi");

    // Re-rise on the acknowledge edge keeps the request pending.
    irq = 8'h08; cycle("r_rise");
    irq = 8'h00; cycle("r_req");
    irq = 8'h08; intack = 1'b1; cycle("r_ack");
    peek_irr(v);
    chk_eq("r_irr3", v & 16'h0008, 16'h0008);
    irq = 8'h00; intack = 1'b0; cycle("r_rel");
    cpu_write(1'b1, 16'h0003, "r_eoi");

    resets = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 8; i++)
        if ($urandom_range(7) == 0) irq[i] = ~irq[i];
      if (m_phase == C_REQ)      intack = ($urandom_range(2) != 0);
      else if (m_phase == C_ACK) intack = ($urandom_range(1) != 0);
      else                       intack = ($urandom_range(9) == 0);
      idle_bus();
      case ($urandom_range(19))
        0: begin
          sel = 1'b1; memwt = 1'b1; a0 = 1'b0;
          wdata = ($urandom_range(2) == 0) ? 16'($urandom) : 16'h0000;
        end
        1, 2, 3: begin
          sel = 1'b1; memwt = 1'b1; a0 = 1'b1;
          wdata = 16'($urandom_range(7));
          for (int i = 7; i >= 0; i--)
            if (m_isr[i] && $urandom_range(1) == 0) wdata = 16'(i);
        end
        4: begin
          memwt = 1'b1; a0 = 1'($urandom_range(1)); wdata = 16'($urandom);
        end
        default: begin
          sel = 1'($urandom_range(1)); a0 = 1'($urandom_range(1));
        end
      endcase
      if (m_phase != C_IDLE && resets < 6 && $urandom_range(49) == 0) begin
        resets++;
        async_reset("arst");
        cpu_write(1'b0, 16'h0000, "arst_unmask");
      end else begin
        cycle("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
